// File: rtl/mips_register_file_pkg.sv
// Shared CPU constants: register file geometry and the named MIPS register indices.
package mips_register_file_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_COUNT  = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_word_t;

  // Conventional MIPS register names used across the core
  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_AT   = 5'd1;
  localparam reg_addr_t REG_V0   = 5'd2;
  localparam reg_addr_t REG_V1   = 5'd3;
  localparam reg_addr_t REG_A0   = 5'd4;
  localparam reg_addr_t REG_GP   = 5'd28;
  localparam reg_addr_t REG_SP   = 5'd29;
  localparam reg_addr_t REG_FP   = 5'd30;
  localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/mips_register_file.sv
// 32 x 32 general-purpose register file: two combinational read ports, one
// synchronous write port and a permanent view of $v0. Index 0 is plain storage.
module mips_register_file
  import mips_register_file_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [4:0]  dst_addr,
  input  logic [31:0] write_data,
  input  logic [4:0]  src_addr_1,
  input  logic [4:0]  src_addr_2,
  output logic [31:0] src_data_1,
  output logic [31:0] src_data_2,
  output logic [31:0] src_data_v0
);

  reg_word_t regs [REG_COUNT];

  // Active-low asynchronous clear; $zero behaviour is left to the datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (write_enable) begin
      regs[dst_addr] <= write_data;
    end
  end

  // No write-to-read bypass: reads see the pre-edge contents
  assign src_data_1  = regs[src_addr_1];
  assign src_data_2  = regs[src_addr_2];
  assign src_data_v0 = regs[REG_V0];

endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file: expectations are queued as stimulus is
// driven and drained against the read ports with immediate assertions.
module tb_mips_register_file;

  logic        clk;
  logic        reset;
  logic        write_enable;
  logic [4:0]  dst_addr;
  logic [31:0] write_data;
  logic [4:0]  src_addr_1;
  logic [4:0]  src_addr_2;
  logic [31:0] src_data_1;
  logic [31:0] src_data_2;
  logic [31:0] src_data_v0;

  typedef struct {
    string       tag;
    int          port;
    logic [4:0]  addr;
    logic [31:0] exp;
  } expect_t;

  expect_t     sb_q[$];
  int          n_vec;
  int          n_err;

  mips_register_file dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .dst_addr     (dst_addr),
    .write_data   (write_data),
    .src_addr_1   (src_addr_1),
    .src_addr_2   (src_addr_2),
    .src_data_1   (src_data_1),
    .src_data_2   (src_data_2),
    .src_data_v0  (src_data_v0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("[TB] FAIL timeout: simulation did not finish within 50000 ns");
    $fatal(1, "[TB] timeout");
  end

  task automatic push_expect(input string tag, input int port,
                             input logic [4:0] addr, input logic [31:0] exp);
    expect_t e;
    e.tag  = tag;
    e.port = port;
    e.addr = addr;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Pops every queued expectation, points the relevant port at it and compares
  task automatic check_output();
    expect_t     e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.port == 1) src_addr_1 = e.addr;
      if (e.port == 2) src_addr_2 = e.addr;
      #1;
      case (e.port)
        1:       obs = src_data_1;
        2:       obs = src_data_2;
        default: obs = src_data_v0;
      endcase
      n_vec++;
      assert (obs === e.exp) else begin
        n_err++;
        $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  // One write cycle, driven on the falling edge and committed on the next rise
  task automatic apply_stimulus(input logic we, input logic [4:0] dst,
                                input logic [31:0] data);
    @(negedge clk);
    write_enable = we;
    dst_addr     = dst;
    write_data   = data;
    @(posedge clk);
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    reset        = 1'b0;
    write_enable = 1'b0;
    dst_addr     = '0;
    write_data   = '0;
    src_addr_1   = '0;
    src_addr_2   = '0;

    // Reset held across one edge, then every register reads zero on both ports
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      push_expect($sformatf("reset_p1_r%0d", i), 1, 5'(i), 32'h0);
      push_expect($sformatf("reset_p2_r%0d", i), 2, 5'(i), 32'h0);
    end
    push_expect("reset_v0", 0, 5'd0, 32'h0);
    check_output();

    // Index 0 is ordinary storage
    apply_stimulus(1'b1, 5'd0, 32'd3);
    push_expect("wr0_r1_untouched", 1, 5'd1, 32'd0);
    push_expect("wr0_r0_stored", 1, 5'd0, 32'd3);
    check_output();

    // Write then a disabled cycle that must change nothing
    apply_stimulus(1'b1, 5'd1, 32'd7);
    apply_stimulus(1'b0, 5'd0, 32'd10);
    push_expect("we0_r1_kept", 1, 5'd1, 32'd7);
    push_expect("we0_r0_kept", 2, 5'd0, 32'd3);
    check_output();

    // $v0 view follows reg 2 only
    apply_stimulus(1'b1, 5'd2, 32'hDEADBEEF);
    push_expect("v0_after_write", 0, 5'd0, 32'hDEADBEEF);
    check_output();
    apply_stimulus(1'b1, 5'd3, 32'h0000_1234);
    apply_stimulus(1'b1, 5'd30, 32'hCAFE_F00D);
    push_expect("v0_stable", 0, 5'd0, 32'hDEADBEEF);
    push_expect("r3_written", 1, 5'd3, 32'h0000_1234);
    push_expect("r30_written", 2, 5'd30, 32'hCAFE_F00D);
    push_expect("r2_on_port1", 1, 5'd2, 32'hDEADBEEF);
    check_output();

    // Dual-port read of regs 5 and 31
    apply_stimulus(1'b1, 5'd5, 32'h1111_1111);
    apply_stimulus(1'b1, 5'd31, 32'h3131_3131);
    src_addr_1 = 5'd5;
    src_addr_2 = 5'd31;
    #1;
    n_vec++;
    assert (src_data_1 === 32'h1111_1111) else begin
      n_err++;
      $error("[TB] FAIL dual_p1_r5: observed %h expected %h", src_data_1, 32'h1111_1111);
    end
    n_vec++;
    assert (src_data_2 === 32'h3131_3131) else begin
      n_err++;
      $error("[TB] FAIL dual_p2_r31: observed %h expected %h", src_data_2, 32'h3131_3131);
    end

    // No bypass: the write of 0x55 is invisible until its edge
    @(negedge clk);
    write_enable = 1'b1;
    dst_addr     = 5'd5;
    write_data   = 32'h55;
    push_expect("nobypass_before_edge", 2, 5'd5, 32'h1111_1111);
    check_output();
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    push_expect("nobypass_after_edge", 2, 5'd5, 32'h55);
    check_output();

    // Asynchronous reset between edges clears everything before the next edge
    @(posedge clk);
    #2;
    reset = 1'b0;
    push_expect("async_rst_p1", 1, 5'd31, 32'h0);
    push_expect("async_rst_p2", 2, 5'd5, 32'h0);
    push_expect("async_rst_v0", 0, 5'd0, 32'h0);
    check_output();

    // Writes are ignored while reset is held, then the pending write lands
    write_enable = 1'b1;
    dst_addr     = 5'd7;
    write_data   = 32'h0000_0077;
    @(posedge clk);
    @(negedge clk);
    push_expect("write_during_reset", 1, 5'd7, 32'h0);
    check_output();
    reset = 1'b1;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    push_expect("first_write_after_reset", 1, 5'd7, 32'h0000_0077);
    push_expect("others_still_zero", 2, 5'd2, 32'h0);
    check_output();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
